// File: rtl/alu_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: opcodes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_nibble_seq_pkg;

  // Opcodes carried on cmd_op / into the nibble slice. 3'd5..3'd7 are reserved.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_nibble_slice.sv
// 4-bit ALU slice with carry/borrow chain input; purely combinational.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: a, b (nibbles), op (opcode), cin (carry/borrow in) -> r (nibble result), cout.
module alu_nibble_slice
  import alu_nibble_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  input  logic       cin,
  output logic [3:0] r,
  output logic       cout
);

  logic [4:0] sum;
  logic [4:0] diff;

  // Bit 4 of the 5-bit difference is the borrow: it is set whenever a < b + cin.
  assign sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};

  always_comb begin
    r    = 4'h0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        r    = sum[3:0];
        cout = sum[4];
      end
      OP_SUB: begin
        r    = diff[3:0];
        cout = diff[4];
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: begin
        // Reserved opcodes produce zero with no carry.
        r    = 4'h0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Word-level ALU built from one 4-bit slice, run LS nibble first, one nibble per clock.
// Latency: NIBBLES+1 cycles from command acceptance to rsp_valid; one command in flight.
// Backpressure: cmd_ready only in IDLE; the response is held in DONE until rsp_ready.
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b in;
//        rsp_valid/rsp_ready/rsp_result/rsp_carry/rsp_zero out.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [4*NIBBLES-1:0]   cmd_a,
  input  logic [4*NIBBLES-1:0]   cmd_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      r_nib;
  logic            cout;
  logic            last_nib;

  // {idx, 2'b00} is the bit offset of the current nibble.
  assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // carry_q is cleared at acceptance, so nibble 0 always sees cin = 0.
  alu_nibble_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .op   (op_q),
    .cin  (carry_q),
    .r    (r_nib),
    .cout (cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  if (last_nib)  state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: only from state and registers, never from inputs.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_DONE);
  end

  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = (result_q == '0);

  // Operand latches, result/carry registers and nibble index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            result_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
          end
        end
        S_EXEC: begin
          result_q[{idx_q, 2'b00} +: 4] <= r_nib;
          carry_q                       <= cout;
          if (!last_nib) begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          // DONE: hold everything stable for the consumer.
        end
      endcase
    end
  end

endmodule
